// File: rtl/i2c_target_regfile.sv
// -----------------------------------------------------------------------------
// i2c_target_regfile
//
// I2C target with a NUM_REGS x 8-bit register file. SCL and SDA are
// oversampled on the system clock. Nothing is clocked from SCL, so the system
// clock must run at least 8x faster than SCL.
//
// Controller protocol:
//   write: START, {DEV_ADDR,0}, pointer, data, data, ... STOP
//   read : START, {DEV_ADDR,1}, data, data, ... (controller NACKs the last byte)
//
// When AUTO_INC is set, the pointer advances after each data byte and wraps
// from NUM_REGS-1 to 0. A repeated START keeps the pointer, so a controller
// can set the pointer with a write and then read from that pointer.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   scl_i/sda_i  pad inputs (asynchronous to clk)
//   sda_oe       1 = pull SDA low, 0 = release
//   loc_we/loc_addr/loc_wdata
//                local fabric write port; out-of-range addresses are ignored
//   loc_rdata    combinational read of regs[loc_addr]; 0 when out of range
//   bus_wr       one-clk pulse for each data byte committed from I2C
//   bus_wr_addr  register written by that commit
//   bus_wr_data  byte written by that commit
//   rw           R/W bit of the last matched address byte (1 = read)
//   busy         high from START to STOP
// -----------------------------------------------------------------------------
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    parameter bit         AUTO_INC    = 1'b1,
    localparam int        PTR_W       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic             loc_we,
    input  logic [PTR_W-1:0] loc_addr,
    input  logic [7:0]       loc_wdata,
    output logic [7:0]       loc_rdata,
    output logic             bus_wr,
    output logic [PTR_W-1:0] bus_wr_addr,
    output logic [7:0]       bus_wr_data,
    output logic             rw,
    output logic             busy
);

    localparam logic [8:0]       NUM_REGS_W = 9'(NUM_REGS);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK      = 4'd8,
        ST_IGNORE    = 4'd9
    } state_t;

    // Pointer advance after a data byte; holds when auto-increment is off.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (!AUTO_INC) begin
            n = p;
        end else if (p == LAST_PTR) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_prev_r;
    logic                   sda_prev_r;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise_s;
    logic                   scl_fall_s;
    logic                   start_s;
    logic                   stop_s;

    state_t                 state_r;
    logic [3:0]             bit_cnt_r;
    logic [6:0]             rx_sh_r;
    logic [6:0]             tx_sh_r;
    logic [PTR_W-1:0]       ptr_r;
    logic                   ack_flag_r;
    logic [7:0]             rx_byte_s;
    logic [7:0]             cur_byte_s;
    logic                   commit_s;

    logic [7:0]             regs_r [NUM_REGS];

    // Pad synchronisers plus one edge-detect stage. Reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
            scl_prev_r <= scl_sync_r[SYNC_STAGES-1];
            sda_prev_r <= sda_sync_r[SYNC_STAGES-1];
        end
    end

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_s & scl_prev_r;
    // SCL must be high in both samples, so an SDA edge that coincides with an
    // SCL edge is never taken as START or STOP.
    assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
    assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;

    // Byte that is complete on the current SCL rise (MSB first).
    assign rx_byte_s  = {rx_sh_r, sda_s};
    assign cur_byte_s = regs_r[ptr_r];
    assign commit_s   = (state_r == ST_WDATA) && scl_rise_s && (bit_cnt_r == 4'd7)
                        && !start_s && !stop_s;

    // Register file. A bus commit takes priority over a local write to the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_s && (ptr_r == PTR_W'(i))) begin
                    regs_r[i] <= rx_byte_s;
                end else if (loc_we && (loc_addr == PTR_W'(i))) begin
                    regs_r[i] <= loc_wdata;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Local read port; addresses past the last register read as zero.
    always_comb begin
        loc_rdata = 8'h00;
        if (9'(loc_addr) < NUM_REGS_W) begin
            loc_rdata = regs_r[loc_addr];
        end else begin
            loc_rdata = 8'h00;
        end
    end

    // Protocol FSM: tracks the transaction, drives SDA and the commit/status outputs.
    // SDA is only changed on SCL falls, apart from the release at START/STOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 4'd0;
            rx_sh_r     <= 7'h00;
            tx_sh_r     <= 7'h00;
            ptr_r       <= {PTR_W{1'b0}};
            ack_flag_r  <= 1'b0;
            sda_oe      <= 1'b0;
            bus_wr      <= 1'b0;
            bus_wr_addr <= {PTR_W{1'b0}};
            bus_wr_data <= 8'h00;
            rw          <= 1'b0;
            busy        <= 1'b0;
        end else begin
            bus_wr <= 1'b0;
            if (stop_s) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= 4'd0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else if (start_s) begin
                // Also a repeated START: the partial byte is dropped, the pointer is kept.
                state_r   <= ST_ADDR;
                bit_cnt_r <= 4'd0;
                sda_oe    <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        sda_oe <= 1'b0;
                    end

                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            rx_sh_r <= rx_byte_s[6:0];
                            if (bit_cnt_r == 4'd7) begin
                                bit_cnt_r  <= 4'd0;
                                ack_flag_r <= 1'b0;
                                if (rx_byte_s[7:1] == DEV_ADDR) begin
                                    rw      <= rx_byte_s[0];
                                    state_r <= ST_ADDR_ACK;
                                end else begin
                                    state_r <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end

                    // First fall drives ACK; second fall ends the ACK slot. For a
                    // read, that second fall also drives the MSB of the first byte.
                    ST_ADDR_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_flag_r) begin
                                sda_oe     <= 1'b1;
                                ack_flag_r <= 1'b1;
                            end else begin
                                ack_flag_r <= 1'b0;
                                if (rw) begin
                                    tx_sh_r   <= cur_byte_s[6:0];
                                    sda_oe    <= ~cur_byte_s[7];
                                    bit_cnt_r <= 4'd1;
                                    state_r   <= ST_RDATA;
                                end else begin
                                    sda_oe    <= 1'b0;
                                    bit_cnt_r <= 4'd0;
                                    state_r   <= ST_PTR;
                                end
                            end
                        end
                    end

                    ST_PTR: begin
                        if (scl_rise_s) begin
                            rx_sh_r <= rx_byte_s[6:0];
                            if (bit_cnt_r == 4'd7) begin
                                bit_cnt_r  <= 4'd0;
                                ack_flag_r <= 1'b0;
                                if ({1'b0, rx_byte_s} < NUM_REGS_W) begin
                                    ptr_r   <= rx_byte_s[PTR_W-1:0];
                                    state_r <= ST_PTR_ACK;
                                end else begin
                                    // Out-of-range pointer: leave SDA released (NACK).
                                    state_r <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end

                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_flag_r) begin
                                sda_oe     <= 1'b1;
                                ack_flag_r <= 1'b1;
                            end else begin
                                sda_oe     <= 1'b0;
                                ack_flag_r <= 1'b0;
                                bit_cnt_r  <= 4'd0;
                                state_r    <= ST_WDATA;
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (scl_rise_s) begin
                            rx_sh_r <= rx_byte_s[6:0];
                            if (bit_cnt_r == 4'd7) begin
                                bus_wr      <= 1'b1;
                                bus_wr_addr <= ptr_r;
                                bus_wr_data <= rx_byte_s;
                                ptr_r       <= next_ptr(ptr_r);
                                bit_cnt_r   <= 4'd0;
                                ack_flag_r  <= 1'b0;
                                state_r     <= ST_WDATA_ACK;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end

                    // bit_cnt_r counts bits already driven. The fall after bit 0 releases SDA.
                    ST_RDATA: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_r == 4'd8) begin
                                sda_oe     <= 1'b0;
                                ack_flag_r <= 1'b0;
                                state_r    <= ST_RACK;
                            end else begin
                                sda_oe    <= ~tx_sh_r[6];
                                tx_sh_r   <= {tx_sh_r[5:0], 1'b0};
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end

                    // The controller's ACK is sampled on the rise. The next byte is
                    // loaded on the following fall, from the already advanced pointer.
                    ST_RACK: begin
                        if (scl_rise_s) begin
                            if (sda_s) begin
                                state_r <= ST_IGNORE;
                            end else begin
                                ptr_r      <= next_ptr(ptr_r);
                                ack_flag_r <= 1'b1;
                            end
                        end else if (scl_fall_s && ack_flag_r) begin
                            tx_sh_r    <= cur_byte_s[6:0];
                            sda_oe     <= ~cur_byte_s[7];
                            bit_cnt_r  <= 4'd1;
                            ack_flag_r <= 1'b0;
                            state_r    <= ST_RDATA;
                        end
                    end

                    ST_IGNORE: begin
                        sda_oe <= 1'b0;
                    end

                    default: begin
                        state_r <= ST_IDLE;
                        sda_oe  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- System-clocked, parametrised successor to the SCL-clocked I2C peripheral: oversamples SCL/SDA on `clk` instead of clocking logic from SCL.
- Owns a NUM_REGS x 8-bit register file exposed to an I2C controller:
  - multi-byte writes and reads with pointer auto-increment;
  - repeated START;
  - address filtering.
- Sits between the board I2C pins (open-drain pad) and FPGA fabric logic, which has its own local register access port.

Parameters:
- DEV_ADDR, 7'h42, 7-bit target address matched after START.
- NUM_REGS, 16, register count, 2..256.
- PTR_W, $clog2(NUM_REGS), pointer width (derived, not overridden).
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i, >=2.
- AUTO_INC, 1, 1 = pointer increments after each data byte; 0 = pointer holds.

Ports:
- clk  in  1  system clock; must be >= 8x SCL frequency.
- rst  in  1  asynchronous, active-low reset.
- scl_i  in  1  SCL pad input.
- sda_i  in  1  SDA pad input.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- loc_we  in  1  local write enable.
- loc_addr  in  PTR_W  local read/write address.
- loc_wdata  in  8  local write data.
- loc_rdata  out  8  combinational read of regs[loc_addr].
- bus_wr  out  1  one-clk pulse when an I2C data byte is committed.
- bus_wr_addr  out  PTR_W  register written by that commit.
- bus_wr_data  out  8  byte written by that commit.
- rw  out  1  R/W bit of the last matched address (1 = read).
- busy  out  1  high from START to STOP.

Behaviour:
- Reset (rst=0, async):
  - regs all 0x00; pointer 0; state IDLE.
  - sda_oe=0, bus_wr=0, bus_wr_addr=0, bus_wr_data=0, rw=0, busy=0.
- Input conditioning and events:
  - scl_i/sda_i pass through SYNC_STAGES flops, then one edge-detect flop.
  - START: SDA fall while SCL high. STOP: SDA rise while SCL high. Both evaluated on synchronised signals.
  - Data is sampled on SCL rise. sda_oe changes only on SCL fall.
- Bits are MSB-first. The bit counter resets on START.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th rise:
    - if [7:1]==DEV_ADDR: latch rw=[0] and go to ADDR_ACK;
    - otherwise go to IGNORE (sda_oe stays 0).
  - ADDR_ACK: sda_oe=1 from the next SCL fall to the following fall. Then:
    - rw=0 -> PTR;
    - rw=1 -> load shift reg from regs[ptr] and go to RDATA.
  - PTR: shift 8 bits. On the 8th rise:
    - byte < NUM_REGS: ptr=byte, go to PTR_ACK (ACK);
    - otherwise ptr unchanged and NACK (sda_oe=0 for that slot), then IGNORE.
  - PTR_ACK then WDATA: on the 8th rise, regs[ptr]=byte; bus_wr pulses one clk with the pre-increment ptr. Then WDATA_ACK (ACK), then back to WDATA.
  - Increment rule: if AUTO_INC, ptr = (ptr+1) mod NUM_REGS, wrapping NUM_REGS-1 -> 0.
  - RDATA:
    - drive sda_oe = ~bit on each SCL fall, 8 bits;
    - release on the fall after bit 0, then sample controller ACK on the next rise;
    - ACK (sda=0): apply the increment rule, reload, stay in RDATA;
    - NACK: go to IGNORE.
  - IGNORE: sda_oe=0; wait for START or STOP.
- START in any state, including mid-byte (repeated START): abort the current byte, no commit, go to ADDR. Pointer is kept, so write-pointer-then-read works.
- STOP in any state: go to IDLE, release SDA, busy=0. A partial byte is discarded.
- Local write vs bus commit to the same address in the same clk: the bus commit wins, and the local write is lost. Different addresses both complete.
- Local writes are allowed at any time. A read byte already loaded into the shift register is not affected.
- sda_oe never asserts while rst=0 or in IDLE/IGNORE.

Test Plan:
- Write: START, 0x84, ptr 0x03, data 0xA5, 0x5A, STOP.
  - ACK on all four bytes.
  - regs[3]=0xA5, regs[4]=0x5A.
  - two bus_wr pulses with addr 3, 4.
- Read with repeated START: START, 0x84, ptr 0x03, rSTART, 0x85.
  - Controller ACKs the first byte and NACKs the second.
  - SDA carries 0xA5 then 0x5A; rw=1; FSM reaches IGNORE, then STOP gives busy=0.
- Wrap and range checks:
  - ptr 0x0F, write 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22.
  - ptr 0x10 -> NACK on the pointer byte, no bus_wr.
- Address mismatch: START, 0x86, 0x00, 0xFF, STOP -> sda_oe never asserts, no bus_wr, regs unchanged.
- Collision: loc_we with addr 3, data 0x77 in the same clk as a bus commit of 0x99 to addr 3 -> regs[3]=0x99.
- Reset mid-write: rst low after the 4th data bit -> all outputs at reset values immediately. After release, the next full transaction behaves normally.
